rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Parametrised N-input, WIDTH-bit arbitrating multiplexer with valid/ready handshakes and a registered output stage. It is the successor to the fixed 5:1 combinational select mux. Selection is decided internally by round-robin or fixed-priority arbitration instead of an external select. It sits where several requesters share one consumer, e.g. instruction-fetch and data-access requests contending for the memory port.

## Interface
- `WIDTH`, 32: data width per channel.
- `N`, 5: number of input channels; N ≥ 2.
- `FIXED_PRI`, 0: 0 = round-robin arbitration; 1 = fixed priority, lowest index wins.
- `SEL_W` (localparam): `max(1, $clog2(N))`.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_data` in N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` in N: per-channel request.
- `in_ready` out N: per-channel accept; at most one bit high.
- `out_data` out WIDTH: registered selected data.
- `out_sel` out SEL_W: index of the channel that supplied `out_data`.
- `out_valid` out 1: output register holds a beat.
- `out_ready` in 1: consumer accepts the beat.

## Operation
- **Transfers.** An input transfer occurs on channel i when `in_valid[i] & in_ready[i]`. An output transfer occurs when `out_valid & out_ready`.
- **Load enable.** `load_en = !out_valid | out_ready`. The output register may load when it is empty or draining in the same cycle.
- **Grant (FIXED_PRI=0).** Scan from `ptr` upward, wrapping from N-1 to 0. The first valid channel wins.
- **Grant (FIXED_PRI=1).** The lowest-index valid channel wins, and `ptr` is ignored.
- **in_ready.** `in_ready = grant & {N{load_en}}`, which is one-hot or zero. It depends combinationally on `in_valid` and `out_ready`. `in_valid` must never depend on `in_ready`.
- **On an input transfer from channel g:**
  - `out_data <= in_data[g]`
  - `out_sel <= g`
  - `out_valid <= 1`
  - `ptr <= (g == N-1) ? 0 : g+1`
- **Draining with no new grant.** If the output transfers and no input transfers, `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- **Stall.** While `out_valid & !out_ready`:
  - `out_data`, `out_sel` and `out_valid` are stable;
  - all `in_ready` bits are 0;
  - `ptr` holds.
- **No requests.** With no `in_valid` asserted, `ptr` holds.
- **Reset values.** `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0. Reset mid-stall discards the held beat. Inputs see `in_ready` = 0 during the reset cycle.

## Timing
- Latency is 1 cycle: an input transfer in cycle t gives `out_valid` = 1 with that data in cycle t+1.
- Full throughput: one beat per cycle while `out_ready` stays high.
- Simultaneous drain and load in the same cycle is legal and required; there is no bubble.
- Fairness: with all N channels continuously valid and `out_ready` = 1, each channel is granted exactly once per N cycles under round-robin.
- No combinational path from `in_data` to any output.

## Structure
- Shared package `mux_pkg`: default `WIDTH` (32) and the `SEL_W` computation function (clog2 with minimum 1).
- Sub-module `rr_arbiter` (N, FIXED_PRI):
  - inputs: `req[N]`, `ptr`;
  - outputs: one-hot `grant[N]` and binary `grant_idx`;
  - purely combinational.
- The top level owns `ptr`, the output register and the handshake logic.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with all `in_valid` = 1. Require `in_ready` = 0 and `out_valid` = 0 throughout; release → first grant is to channel 0.
- **Round-robin fairness.** N=5, all valid, `out_ready` = 1, `in_data[i]` = 0xA0+i. Require `out_sel` sequence 0,1,2,3,4,0 on consecutive cycles, with matching data.
- **Backpressure.** Drop `out_ready` for 3 cycles. Require `out_data`/`out_sel` stable, `in_ready` = 0 and `ptr` unchanged. Raise `out_ready` → the next beat appears in the following cycle with no loss.
- **Wrap / sparse.** Only channels 4 and 1 valid, with `ptr` = 3. Require grant order 4, 1, 4, 1.
- **FIXED_PRI=1.** Channels 0 and 3 valid with `in_valid[0]` held. Require channel 3 never granted until `in_valid[0]` drops, then granted the next cycle.
- **Drain without refill.** Single beat from channel 2, then all `in_valid` = 0. Require `out_valid` to fall one cycle after the output transfer, with `out_data` retaining the channel-2 value.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrating mux family.
package mux_pkg;

  localparam int unsigned DefWidth = 32;

  // Select-index width: clog2 of the channel count, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed priority (lowest index wins).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N         = 5,
  parameter bit          FIXED_PRI = 1'b0,
  localparam int unsigned SEL_W    = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      // ptr is always < N, so a single subtraction is enough to wrap.
      idx = FIXED_PRI ? off : (32'(ptr) + off);
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input arbitrating mux with valid/ready handshakes and a registered output stage.
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned N         = 5,
  parameter bit          FIXED_PRI = 1'b0,
  localparam int unsigned SEL_W    = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             load_en;
  logic             in_xfer;

  rr_arbiter #(
    .N         (N),
    .FIXED_PRI (FIXED_PRI)
  ) u_arbiter (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    load_en  = !out_valid_q || out_ready;
    // Held low during reset so no beat is accepted and then discarded.
    in_ready = rst ? '0 : (grant & {N{load_en}});
    in_xfer  = |in_ready;
    sel_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) begin
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      out_data_d  = sel_data;
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      ptr_d       = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: one round-robin instance and one fixed-priority instance.
module tb_rr_arb_mux;

  localparam int unsigned W = 32;
  localparam int unsigned N = 5;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;

  logic [N-1:0]   rr_in_valid, rr_in_ready;
  logic [W-1:0]   rr_out_data;
  logic [2:0]     rr_out_sel;
  logic           rr_out_valid, rr_out_ready;

  logic [N-1:0]   fp_in_valid, fp_in_ready;
  logic [W-1:0]   fp_out_data;
  logic [2:0]     fp_out_sel;
  logic           fp_out_valid, fp_out_ready;

  int checks;
  int failures;

  rr_arb_mux #(.WIDTH(W), .N(N), .FIXED_PRI(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (rr_in_valid),
    .in_ready  (rr_in_ready),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_valid (rr_out_valid),
    .out_ready (rr_out_ready)
  );

  rr_arb_mux #(.WIDTH(W), .N(N), .FIXED_PRI(1'b1)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (fp_in_valid),
    .in_ready  (fp_in_ready),
    .out_data  (fp_out_data),
    .out_sel   (fp_out_sel),
    .out_valid (fp_out_valid),
    .out_ready (fp_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    rr_in_valid  = '1;
    rr_out_ready = 1'b1;
    fp_in_valid  = '0;
    fp_out_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      in_data[i*W +: W] = 32'hA0 + i;
    end

    // Reset held two cycles with every channel requesting.
    for (int c = 0; c < 2; c++) begin
      tick();
      check_eq("rst_in_ready", 32'(rr_in_ready), 32'h0);
      check_eq("rst_out_valid", 32'(rr_out_valid), 32'h0);
    end
    check_eq("rst_out_data", rr_out_data, 32'h0);
    check_eq("rst_out_sel", 32'(rr_out_sel), 32'h0);
    rst = 1'b0;
    #1;
    check_eq("first_grant", 32'(rr_in_ready), 32'h01);

    // Round-robin fairness: 0,1,2,3,4,0.
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("rr_valid", 32'(rr_out_valid), 32'h1);
      check_eq("rr_sel", 32'(rr_out_sel), 32'(k % 5));
      check_eq("rr_data", rr_out_data, 32'hA0 + 32'(k % 5));
    end

    // Backpressure for 3 cycles; held beat is channel 0, ptr points at 1.
    rr_out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check_eq("bp_in_ready", 32'(rr_in_ready), 32'h0);
      check_eq("bp_sel", 32'(rr_out_sel), 32'h0);
      check_eq("bp_data", rr_out_data, 32'hA0);
      check_eq("bp_valid", 32'(rr_out_valid), 32'h1);
      check_eq("bp_ptr", 32'(dut.ptr_q), 32'h1);
      tick();
    end
    rr_out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(rr_in_ready), 32'h02);
    tick();
    check_eq("bp_next_sel", 32'(rr_out_sel), 32'h1);
    check_eq("bp_next_data", rr_out_data, 32'hA1);

    // Advance to ptr = 3, then only channels 4 and 1 request.
    tick();
    check_eq("pre_wrap_sel", 32'(rr_out_sel), 32'h2);
    check_eq("pre_wrap_ptr", 32'(dut.ptr_q), 32'h3);
    rr_in_valid = 5'b10010;
    #1;
    check_eq("wrap_ready", 32'(rr_in_ready), 32'h10);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("wrap_sel", 32'(rr_out_sel), (k % 2 == 0) ? 32'h4 : 32'h1);
      check_eq("wrap_data", rr_out_data, (k % 2 == 0) ? 32'hA4 : 32'hA1);
    end

    // Drain without refill: one beat from channel 2, then nothing.
    rr_in_valid = 5'b00100;
    tick();
    check_eq("drain_beat_valid", 32'(rr_out_valid), 32'h1);
    check_eq("drain_beat_sel", 32'(rr_out_sel), 32'h2);
    rr_in_valid = '0;
    #1;
    check_eq("drain_in_ready", 32'(rr_in_ready), 32'h0);
    tick();
    check_eq("drain_valid", 32'(rr_out_valid), 32'h0);
    check_eq("drain_data", rr_out_data, 32'hA2);
    check_eq("drain_sel", 32'(rr_out_sel), 32'h2);
    tick();
    check_eq("idle_ptr", 32'(dut.ptr_q), 32'h3);

    // Reset during a stall discards the held beat.
    rr_in_valid = 5'b00001;
    tick();
    rr_in_valid  = '0;
    rr_out_ready = 1'b0;
    tick();
    check_eq("stall_valid", 32'(rr_out_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", 32'(rr_out_valid), 32'h0);
    check_eq("midrst_data", rr_out_data, 32'h0);
    check_eq("midrst_ptr", 32'(dut.ptr_q), 32'h0);
    rr_out_ready = 1'b1;

    // Fixed priority: channel 0 starves channel 3 until it drops.
    fp_in_valid = 5'b01001;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("fp_ready0", 32'(fp_in_ready), 32'h01);
      tick();
      check_eq("fp_sel0", 32'(fp_out_sel), 32'h0);
      check_eq("fp_data0", fp_out_data, 32'hA0);
    end
    fp_in_valid = 5'b01000;
    #1;
    check_eq("fp_ready3", 32'(fp_in_ready), 32'h08);
    tick();
    check_eq("fp_sel3", 32'(fp_out_sel), 32'h3);
    check_eq("fp_data3", fp_out_data, 32'hA3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
